dmem_responder: RTL and testbench

- Data-memory responder for the MEM pipeline stage. It accepts one load or store request at a time over a valid/ready handshake.
- It models a configurable number of wait states, performs the word access, and returns a one-cycle response.
- It drives a stall back to the pipeline until the access completes, and flags misaligned or out-of-range addresses.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// counter width and the byte-to-word address offset.
package dmem_pkg;

  // Responder FSM states; the encoding is fixed so it can be probed externally.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte address bits below the word index (32-bit words).
  localparam int unsigned WORD_OFS = 2;

  // Width of the wait-state counter (WAIT_CYCLES legal range 0..15).
  localparam int unsigned CNT_W = 4;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with write enable and registered read data.
// A read updates rdata_o on the enabled edge; a write leaves rdata_o unchanged.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Single-port access: store on write, capture the addressed word on read.
  // NOTE: the storage array has no reset branch; a reset would turn the RAM
  // into a flop bank. Consumers must mask rdata_o until a read has happened.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of always-block evaluation order.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES states, performs the word access on entry into RESP and returns
// a one-cycle response with error flag. Stalls the pipeline while busy.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam logic [CNT_W-1:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit               NO_WAIT   = (WAIT_CYCLES == 0);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               resp_valid_q;
  logic               resp_err_q;
  logic               load_ok_q;

  logic               accept;
  logic               enter_resp;
  logic               acc_write;
  logic [31:0]        acc_addr;
  logic [31:0]        acc_wdata;
  logic               acc_misaligned;
  logic               acc_oob;
  logic               acc_err;
  logic [ADDR_W-1:0]  acc_idx;
  logic               mem_en;
  logic               mem_we;
  logic [31:0]        mem_rdata;

  assign accept     = (state_q == IDLE) && req_valid;
  assign enter_resp = (accept && NO_WAIT) || ((state_q == WAIT) && (cnt_q == 4'd1));

  // Select the transaction that reaches the array this cycle: the live request
  // when going straight from IDLE to RESP, otherwise the latched copy.
  // NOTE: every output of this block is given a default before any branch so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    acc_write = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign acc_misaligned = (acc_addr[WORD_OFS-1:0] != '0);
  assign acc_oob        = ((acc_addr >> (ADDR_W + WORD_OFS)) != '0);
  assign acc_err        = acc_misaligned || acc_oob;
  assign acc_idx        = acc_addr[ADDR_W+WORD_OFS-1:WORD_OFS];

  // Erroneous stores never touch the array; loads are always issued on RESP
  // entry and masked afterwards if they were in error.
  assign mem_en = enter_resp;
  assign mem_we = enter_resp && acc_write && !acc_err;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_array (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (mem_rdata)
  );

  // Request FSM with wait-state counter, request latch and registered response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_ok_q    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_ok_q    <= 1'b0;
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= acc_err;
        load_ok_q    <= !acc_write && !acc_err;
      end

      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= WAIT_INIT;
            state_q <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Load data is only presented for a clean load; stores and errors read as 0.
  assign resp_rdata = load_ok_q ? mem_rdata : 32'h0;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q == WAIT) || ((state_q == IDLE) && req_valid);

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 wait states and 0 wait states)
// share one request bus, gated by sel. A driver pushes expected responses
// from a word-array reference model; a monitor pops and compares them.
module tb_dmem_responder;

  localparam int ADDR_W = 8;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    bit          chk_rd;
    int          acc_cyc;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  bit          sel       = 1'b0;

  logic [1:0]        vld;
  logic [1:0]        rdy;
  logic [1:0]        rv;
  logic [1:0]        err;
  logic [1:0]        stl;
  logic [1:0][31:0]  rd;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  logic [31:0] mdl_mem   [2][2**ADDR_W];
  bit          mdl_known [2][2**ADDR_W];
  int          stall_cnt [2];

  assign vld = {req_valid & sel, req_valid & ~sel};

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (vld[0]),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (rdy[0]),
    .resp_valid (rv[0]),
    .resp_rdata (rd[0]),
    .resp_err   (err[0]),
    .stall      (stl[0])
  );

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (vld[1]),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (rdy[1]),
    .resp_valid (rv[1]),
    .resp_rdata (rd[1]),
    .resp_err   (err[1]),
    .stall      (stl[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic count_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Presents one request to the selected instance; called at posedge+1.
  // On acceptance the reference model is updated and the expectation queued.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit hold);
    exp_t e;
    bit   ok;
    int   k;
    int   idx;
    k = int'(sel);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (rdy[k]) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      count_fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    e.dut     = k;
    e.acc_cyc = cyc;
    e.err     = (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'h0);
    e.rdata   = 32'h0;
    e.chk_rd  = 1'b1;
    idx       = int'(a[ADDR_W+1:2]);
    if (!e.err) begin
      if (wr) begin
        mdl_mem[k][idx]   = d;
        mdl_known[k][idx] = 1'b1;
      end else begin
        e.chk_rd = mdl_known[k][idx];
        e.rdata  = mdl_mem[k][idx];
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_outstanding", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int          r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    a = 32'($urandom_range(0, 15)) << 2;
    if (r == 0) a = a | 32'($urandom_range(1, 3));
    else if (r == 1) a = a | (32'h1 << $urandom_range(ADDR_W + 2, 31));
    return a;
  endfunction

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      issue(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'($urandom_range(0, 1)) && (i != n - 1));
    end
    drain();
  endtask

  // Monitor: on every response pop the oldest expectation and compare; also
  // count stall cycles per request (acceptance cycle plus wait states).
  initial begin
    exp_t e;
    stall_cnt[0] = 0;
    stall_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt[0] = 0;
        stall_cnt[1] = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (rv[k]) begin
            check($sformatf("stall_in_resp_dut%0d", k), 32'(stl[k]), 32'h0);
            check($sformatf("stall_cycles_dut%0d", k), stall_cnt[k], wc(k) + 1);
            stall_cnt[k] = 0;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL spurious_resp dut%0d: resp_valid with nothing outstanding (cycle %0d)", k, cyc);
            end else begin
              e = exp_q.pop_front();
              check("resp_dut", k, e.dut);
              check("resp_latency", cyc - e.acc_cyc, wc(k) + 1);
              check("resp_err", 32'(err[k]), 32'(e.err));
              if (e.chk_rd) check("resp_rdata", rd[k], e.rdata);
            end
          end else if (stl[k]) begin
            stall_cnt[k]++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_resp_valid", 32'(rv[k]), 32'h0);
      check("reset_resp_rdata", rd[k], 32'h0);
      check("reset_resp_err", 32'(err[k]), 32'h0);
      check("reset_stall", 32'(stl[k]), 32'h0);
      check("reset_req_ready", 32'(rdy[k]), 32'h1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-wait-state instance: store/load, misaligned store, out of range.
    sel = 1'b0;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 1'b0);
    issue(1'b1, 32'h20, 32'h0BADF00D, 1'b0);
    issue(1'b1, 32'h22, 32'hFFFFFFFF, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 1'b0);
    issue(1'b0, 32'h400, 32'h0, 1'b0);
    drain();

    // Back-to-back: req_valid held high across consecutive requests.
    for (int i = 0; i < 6; i++) begin
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, i != 5);
    end
    drain();

    // Reset while a store sits in WAIT: the store must be dropped.
    issue(1'b1, 32'h8, 32'h11112222, 1'b0);
    drain();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h8;
    req_wdata = 32'hAAAA5555;
    @(negedge clk);
    check("rst_test_ready", 32'(rdy[0]), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_test_stall_in_wait", 32'(stl[0]), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_resp_valid", 32'(rv[0]), 32'h0);
    check("rst_mid_resp_rdata", rd[0], 32'h0);
    check("rst_mid_resp_err", 32'(err[0]), 32'h0);
    check("rst_mid_stall", 32'(stl[0]), 32'h0);
    check("rst_mid_req_ready", 32'(rdy[0]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(1'b0, 32'h8, 32'h0, 1'b0);
    drain();

    random_phase(60);

    // Zero-wait-state instance.
    sel = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b1, 32'h0, 32'h12345678, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 1'b0);
    drain();
    random_phase(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dmem_responder
